// File: rtl/pad_io_ctrl_pkg.sv
// Shared types and constants for the pad I/O controller.
//   pad_io_state_e : attribute-change sequencer states
//   SettleCycles   : cycles the pad is held with oe low after new attributes land
//   attribute bit indices for the pad attribute vector
package pad_io_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        APPLY  = 2'd2,
        SETTLE = 2'd3
    } pad_io_state_e;

    localparam int unsigned SettleCycles = 2;
    localparam int unsigned SettleW      = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

    // Attribute vector bit positions
    localparam int unsigned Inv       = 0;
    localparam int unsigned OpenDrain = 1;
    localparam int unsigned PullEn    = 2;
    localparam int unsigned PullSel   = 3;
    localparam int unsigned Keeper    = 4;
    localparam int unsigned Schmitt   = 5;
    localparam int unsigned Slew      = 6;
    localparam int unsigned DriveLsb  = 7;
    localparam int unsigned DriveMsb  = 8;

endpackage

// File: rtl/pad_io_filter.sv
// Pad input conditioning: enable gating, synchronisation, debounce and edge pulses.
//   in_i          : raw asynchronous pad input (may be x/z while ie_i=0)
//   ie_i          : pad input enable; gates in_i before the synchroniser
//   filt_en_i     : debounce enable
//   filt_thresh_i : debounce threshold T; a new level must persist T+1 cycles
//   edge_mask_i   : suppresses rise/fall pulses (edge is dropped, level still tracks)
//   in_val_o      : conditioned level
//   rise_o/fall_o : one-cycle pulses in the first cycle in_val_o shows a new level
module pad_io_filter #(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_i,
    input  logic                ie_i,
    input  logic                filt_en_i,
    input  logic [CntWidth-1:0] filt_thresh_i,
    input  logic                edge_mask_i,
    output logic                in_val_o,
    output logic                rise_o,
    output logic                fall_o
);

    logic                gated;
    logic                sync;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_nxt;
    logic                in_val_nxt;

    // Gate before synchronising so an undriven pad never reaches the flops
    assign gated = in_i & ie_i;

    prim_flop_2sync #(
        .Width      (1),
        .ResetValue (1'b0)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (gated),
        .q_o    (sync)
    );

    // Debounce: count consecutive cycles the synchronised level disagrees
    always_comb begin
        cnt_nxt    = '0;
        in_val_nxt = in_val_o;
        if (!filt_en_i) begin
            in_val_nxt = sync;
        end else if (sync != in_val_o) begin
            if (cnt_q == filt_thresh_i) begin
                in_val_nxt = sync;
            end else begin
                cnt_nxt = cnt_q + CntWidth'(1);
            end
        end
    end

    // Pulses are computed from the next level so they are registered yet
    // coincide with the first cycle in_val_o carries the new value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            in_val_o <= 1'b0;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
        end else begin
            cnt_q    <= cnt_nxt;
            in_val_o <= in_val_nxt;
            rise_o   <= in_val_nxt & ~in_val_o & ~edge_mask_i;
            fall_o   <= ~in_val_nxt & in_val_o & ~edge_mask_i;
        end
    end

endmodule

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for asynchronous inputs.
//   clk_i, rst_ni : clock, async active-low reset
//   d_i           : asynchronous data
//   q_o           : data synchronised to clk_i
module prim_flop_2sync #(
    parameter int unsigned     Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetValue;
            q_o    <= ResetValue;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pad_io_ctrl.sv
// Digital-side controller for one bidirectional pad.
//   cfg_*         : attribute/out/oe/ie write request; cfg_ready_o high only in IDLE
//   warl_i        : pad-supported attribute mask applied to every write
//   attr_o/out_o/oe_o/ie_o : registered pad controls; attribute changes while
//                   driving go break-before-make (oe low through DRAIN/APPLY/SETTLE)
//   in_i          : raw pad input
//   in_val_o/rise_o/fall_o : conditioned input level and edge pulses
//   filt_en_i/filt_thresh_i : debounce control
module pad_io_ctrl
    import pad_io_ctrl_pkg::*;
#(
    parameter int unsigned AttrDw   = 10,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [AttrDw-1:0]   cfg_attr_i,
    input  logic                cfg_out_i,
    input  logic                cfg_oe_i,
    input  logic                cfg_ie_i,
    input  logic                filt_en_i,
    input  logic [CntWidth-1:0] filt_thresh_i,
    input  logic [AttrDw-1:0]   warl_i,
    output logic [AttrDw-1:0]   attr_o,
    output logic                out_o,
    output logic                oe_o,
    output logic                ie_o,
    input  logic                in_i,
    output logic                in_val_o,
    output logic                rise_o,
    output logic                fall_o
);

    if (AttrDw < 9) begin : g_attr_dw_check
        $fatal(1, "pad_io_ctrl: AttrDw must be at least 9");
    end

    pad_io_state_e      state_q, state_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [AttrDw-1:0]  st_attr_q, st_attr_d;
    logic               st_out_q, st_out_d;
    logic               st_oe_q, st_oe_d;
    logic               st_ie_q, st_ie_d;
    logic [AttrDw-1:0]  attr_d;
    logic               out_d, oe_d, ie_d;
    logic [AttrDw-1:0]  attr_n;

    assign attr_n      = cfg_attr_i & warl_i;
    assign cfg_ready_o = (state_q == IDLE);

    // Sequencer next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        st_attr_d = st_attr_q;
        st_out_d  = st_out_q;
        st_oe_d   = st_oe_q;
        st_ie_d   = st_ie_q;
        attr_d    = attr_o;
        out_d     = out_o;
        oe_d      = oe_o;
        ie_d      = ie_o;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    if (!oe_o || (attr_n == attr_o)) begin
                        attr_d = attr_n;
                        out_d  = cfg_out_i;
                        oe_d   = cfg_oe_i;
                        ie_d   = cfg_ie_i;
                    end else begin
                        st_attr_d = attr_n;
                        st_out_d  = cfg_out_i;
                        st_oe_d   = cfg_oe_i;
                        st_ie_d   = cfg_ie_i;
                        oe_d      = 1'b0;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                attr_d  = st_attr_q;
                out_d   = st_out_q;
                ie_d    = st_ie_q;
                state_d = APPLY;
            end
            APPLY: begin
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == SettleW'(SettleCycles - 1)) begin
                    oe_d    = st_oe_q;
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q + SettleW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and pad control registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            st_attr_q <= '0;
            st_out_q  <= 1'b0;
            st_oe_q   <= 1'b0;
            st_ie_q   <= 1'b0;
            attr_o    <= '0;
            out_o     <= 1'b0;
            oe_o      <= 1'b0;
            ie_o      <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            st_attr_q <= st_attr_d;
            st_out_q  <= st_out_d;
            st_oe_q   <= st_oe_d;
            st_ie_q   <= st_ie_d;
            attr_o    <= attr_d;
            out_o     <= out_d;
            oe_o      <= oe_d;
            ie_o      <= ie_d;
        end
    end

    // Mask from next state so a registered pulse is dropped in any cycle
    // the sequencer is busy
    pad_io_filter #(
        .CntWidth (CntWidth)
    ) u_filter (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .in_i          (in_i),
        .ie_i          (ie_o),
        .filt_en_i     (filt_en_i),
        .filt_thresh_i (filt_thresh_i),
        .edge_mask_i   (state_d != IDLE),
        .in_val_o      (in_val_o),
        .rise_o        (rise_o),
        .fall_o        (fall_o)
    );

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Self-checking bench for pad_io_ctrl: directed scenarios followed by random
// traffic, all checked every cycle against a cycle-level behavioural model.
module tb_pad_io_ctrl;

    localparam int unsigned AttrDw   = 10;
    localparam int unsigned CntWidth = 16;

    logic                clk;
    logic                rst_n;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [AttrDw-1:0]   cfg_attr;
    logic                cfg_out;
    logic                cfg_oe;
    logic                cfg_ie;
    logic                filt_en;
    logic [CntWidth-1:0] filt_thresh;
    logic [AttrDw-1:0]   warl;
    logic [AttrDw-1:0]   attr;
    logic                pad_out;
    logic                pad_oe;
    logic                pad_ie;
    logic                pad_in;
    logic                in_val;
    logic                rise;
    logic                fall;

    int errors = 0;
    int checks = 0;

    pad_io_ctrl #(
        .AttrDw   (AttrDw),
        .CntWidth (CntWidth)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_attr_i    (cfg_attr),
        .cfg_out_i     (cfg_out),
        .cfg_oe_i      (cfg_oe),
        .cfg_ie_i      (cfg_ie),
        .filt_en_i     (filt_en),
        .filt_thresh_i (filt_thresh),
        .warl_i        (warl),
        .attr_o        (attr),
        .out_o         (pad_out),
        .oe_o          (pad_oe),
        .ie_o          (pad_ie),
        .in_i          (pad_in),
        .in_val_o      (in_val),
        .rise_o        (rise),
        .fall_o        (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: busy counts remaining non-idle cycles of a
    // break-before-make sequence (4 = drain, 3 = apply, 2..1 = settle)
    logic [AttrDw-1:0] m_attr, s_attr;
    logic              m_out, m_oe, m_ie, s_out, s_oe, s_ie;
    int                busy;
    logic              m_p1, m_p2, m_val, m_rise, m_fall;
    int                streak;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_attr = '0; s_attr = '0;
        m_out = 0; m_oe = 0; m_ie = 0; s_out = 0; s_oe = 0; s_ie = 0;
        busy = 0;
        m_p1 = 0; m_p2 = 0; m_val = 0; m_rise = 0; m_fall = 0;
        streak = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        logic              g;
        logic              val_n;
        logic [AttrDw-1:0] an;
        g = m_ie ? pad_in : 1'b0;
        if (!filt_en) begin
            val_n  = m_p2;
            streak = 0;
        end else if (m_p2 != m_val) begin
            streak++;
            if (streak > int'(filt_thresh)) begin
                val_n  = m_p2;
                streak = 0;
            end else begin
                val_n = m_val;
            end
        end else begin
            val_n  = m_val;
            streak = 0;
        end
        m_p2 = m_p1;
        m_p1 = g;

        an = cfg_attr & warl;
        if (busy == 0) begin
            if (cfg_valid) begin
                if (!m_oe || an == m_attr) begin
                    m_attr = an; m_out = cfg_out; m_oe = cfg_oe; m_ie = cfg_ie;
                end else begin
                    s_attr = an; s_out = cfg_out; s_oe = cfg_oe; s_ie = cfg_ie;
                    m_oe = 0;
                    busy = 4;
                end
            end
        end else if (busy == 4) begin
            m_attr = s_attr; m_out = s_out; m_ie = s_ie;
            busy = 3;
        end else if (busy == 1) begin
            m_oe = s_oe;
            busy = 0;
        end else begin
            busy--;
        end

        m_rise = val_n & ~m_val & (busy == 0);
        m_fall = ~val_n & m_val & (busy == 0);
        m_val  = val_n;
    endtask

    task automatic compare_all();
        check("attr_o", 32'(attr), 32'(m_attr));
        check("out_o", 32'(pad_out), 32'(m_out));
        check("oe_o", 32'(pad_oe), 32'(m_oe));
        check("ie_o", 32'(pad_ie), 32'(m_ie));
        check("cfg_ready_o", 32'(cfg_ready), 32'(busy == 0));
        check("in_val_o", 32'(in_val), 32'(m_val));
        check("rise_o", 32'(rise), 32'(m_rise));
        check("fall_o", 32'(fall), 32'(m_fall));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic write(input logic [AttrDw-1:0] a, input logic o, input logic e, input logic i);
        cfg_valid = 1; cfg_attr = a; cfg_out = o; cfg_oe = e; cfg_ie = i;
        tick();
        cfg_valid = 0;
    endtask

    initial begin
        int n;
        int seen;
        rst_n = 0; cfg_valid = 0; cfg_attr = '0; cfg_out = 0; cfg_oe = 0; cfg_ie = 0;
        filt_en = 0; filt_thresh = '0; warl = '1; pad_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1;
        tick();

        // WARL masking on the fast path
        warl = 10'h19F;
        write(10'h3FF, 0, 0, 1);
        check("warl_attr", 32'(attr), 32'h19F);
        check("warl_ready", 32'(cfg_ready), 32'd1);

        // Break-before-make with an ignored write mid-sequence
        warl = '1;
        write(10'h004, 0, 1, 1);
        write(10'h008, 1, 1, 1);
        n = (pad_oe === 1'b0) ? 1 : 0;
        check("bbm_attr_hold", 32'(attr), 32'h004);
        cfg_valid = 1; cfg_attr = 10'h3FF; cfg_out = 0; cfg_oe = 0;
        tick();
        if (pad_oe === 1'b0) n++;
        check("bbm_attr_apply", 32'(attr), 32'h008);
        cfg_valid = 0;
        for (int i = 0; i < 8 && pad_oe !== 1'b1; i++) begin
            tick();
            if (pad_oe === 1'b0) n++;
        end
        check("bbm_oe_low_cycles", 32'(n), 32'd4);
        check("bbm_final_attr", 32'(attr), 32'h008);
        check("bbm_final_oe", 32'(pad_oe), 32'd1);

        // Unfiltered latency
        pad_in = 1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (in_val === 1'b1) break;
        end
        check("nofilt_latency", 32'(n), 32'd3);
        check("nofilt_rise", 32'(rise), 32'd1);
        tick();
        check("nofilt_rise_1cyc", 32'(rise), 32'd0);

        // Debounce, T=5
        pad_in = 0;
        repeat (5) tick();
        filt_en = 1; filt_thresh = 16'd5;
        pad_in = 1;
        repeat (5) tick();
        pad_in = 0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (in_val !== 1'b0 || rise !== 1'b0) seen++;
        end
        check("glitch_rejected", 32'(seen), 32'd0);
        pad_in = 1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n++;
            if (in_val === 1'b1) break;
        end
        check("filt_latency", 32'(n), 32'd8);
        repeat (19) tick();
        pad_in = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fall === 1'b1) seen++;
        end
        check("filt_fall_seen", 32'(seen), 32'd1);

        // ie gating: undriven and high input ignored
        filt_en = 0;
        write(10'h008, 1, 1, 0);
        pad_in = 1'bx;
        repeat (6) tick();
        pad_in = 1;
        repeat (6) tick();
        check("ie_gate", 32'(in_val), 32'd0);
        pad_in = 0;
        repeat (2) tick();

        // Edge landing mid-sequence is masked, level still follows
        write(10'h008, 1, 1, 1);
        repeat (4) tick();
        pad_in = 1;
        cfg_valid = 1; cfg_attr = 10'h010; cfg_out = 1; cfg_oe = 1; cfg_ie = 1;
        seen = 0;
        tick();
        cfg_valid = 0;
        if (rise === 1'b1) seen++;
        repeat (5) begin
            tick();
            if (rise === 1'b1) seen++;
        end
        check("mask_rise", 32'(seen), 32'd0);
        check("mask_level", 32'(in_val), 32'd1);

        // Reset asserted mid-SETTLE
        write(10'h020, 0, 1, 1);
        repeat (2) tick();
        #2 rst_n = 0;
        #1;
        model_reset();
        check("rst_attr", 32'(attr), 32'd0);
        check("rst_oe", 32'(pad_oe), 32'd0);
        check("rst_ie", 32'(pad_ie), 32'd0);
        check("rst_in_val", 32'(in_val), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        compare_all();
        @(posedge clk);
        #1 rst_n = 1;
        pad_in = 0;
        tick();

        // Random traffic
        warl = '1;
        for (int seg = 0; seg < 8; seg++) begin
            filt_en = 0;
            repeat (4) tick();
            filt_en = 1'($urandom_range(0, 1));
            filt_thresh = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) warl = 10'($urandom);
            for (int c = 0; c < 200; c++) begin
                cfg_valid = ($urandom_range(0, 9) < 3);
                cfg_attr  = ($urandom_range(0, 1) == 1) ? m_attr : 10'($urandom);
                cfg_out   = 1'($urandom);
                cfg_oe    = ($urandom_range(0, 3) != 0);
                cfg_ie    = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 6) == 0) pad_in = ~pad_in;
                tick();
            end
            cfg_valid = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pad_io_ctrl.md
Name: pad_io_ctrl

Overview:
- Digital-side controller for one bidirectional pad instance; it is the producer of the pad's out/oe/ie/attr inputs and the consumer of its input data and WARL mask.
- Masks requested attributes against the pad's WARL mask.
- Sequences attribute changes break-before-make, so the pad never drives while attributes are in flux.
- Synchronises, debounces and edge-detects the asynchronous pad input for the GPIO/peripheral layer.

Parameters:
- AttrDw, 10, attribute vector width; must be >= 9.
- CntWidth, 16, width of the debounce counter and threshold.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- cfg_valid_i  input  1  configuration write request.
- cfg_ready_o  output  1  configuration accepted; high only in IDLE.
- cfg_attr_i  input  AttrDw  requested pad attributes.
- cfg_out_i  input  1  requested output data.
- cfg_oe_i  input  1  requested output enable.
- cfg_ie_i  input  1  requested input enable.
- filt_en_i  input  1  debounce filter enable (quasi-static).
- filt_thresh_i  input  CntWidth  debounce threshold T (quasi-static).
- warl_i  input  AttrDw  supported-attribute mask from the pad.
- attr_o  output  AttrDw  applied attributes to the pad.
- out_o  output  1  output data to the pad.
- oe_o  output  1  output enable to the pad.
- ie_o  output  1  input enable to the pad.
- in_i  input  1  raw pad input; asynchronous, may be z/x when ie_o=0.
- in_val_o  output  1  conditioned input level.
- rise_o  output  1  one-cycle pulse on a 0->1 transition of in_val_o.
- fall_o  output  1  one-cycle pulse on a 1->0 transition of in_val_o.

Behaviour:
- Reset values: attr_o=0, out_o=0, oe_o=0, ie_o=0, in_val_o=0, rise_o=0, fall_o=0, state=IDLE, cfg_ready_o=1. All outputs are registered except cfg_ready_o, which is decoded from state.
- Write handshake: a write is accepted when cfg_valid_i & cfg_ready_o. On acceptance, stage attr_n = cfg_attr_i & warl_i, plus cfg_out_i, cfg_oe_i and cfg_ie_i. cfg_valid_i while not ready is ignored; no queueing.
- Fast path: taken when the write is accepted and either oe_o=0 or attr_n == attr_o. All staged values appear on the outputs in the next cycle, and the FSM stays in IDLE.
- Slow path: taken when oe_o=1 and attr_n != attr_o.
  - IDLE -> DRAIN: in the next cycle oe_o=0; attr_o and out_o are unchanged.
  - DRAIN -> APPLY: attr_o<=attr_n, out_o<=staged out, ie_o<=staged ie; oe_o stays 0.
  - APPLY -> SETTLE: stays in SETTLE for SettleCycles=2 cycles with oe_o=0.
  - SETTLE -> IDLE: oe_o<=staged oe.
  - Total: oe_o is low for 4 cycles; cfg_ready_o is low for DRAIN+APPLY+2xSETTLE (4 cycles).
- Reset mid-sequence: asynchronously returns to IDLE with oe_o=0 and all reset values; the staged write is lost.
- Input path:
  - Gate: g = in_i & ie_o, so z/x never propagates when input is disabled.
  - Synchronise g through 2 flops.
  - Filter off: in_val_o<=sync value. Latency from an in_i change to in_val_o is 3 cycles.
  - Filter on: counter cnt (CntWidth bits) resets to 0 whenever sync == in_val_o.
  - While sync != in_val_o: if cnt == T, then in_val_o<=sync and cnt<=0; else cnt<=cnt+1. cnt never wraps, since T <= 2^CntWidth-1.
  - Filter latency is 3+T cycles; T=0 is identical to filter off.
  - A glitch of T or fewer sync cycles is rejected.
- Edges:
  - rise_o = in_val_o & ~in_val_d; fall_o = ~in_val_o & in_val_d, where in_val_d is a registered copy of in_val_o.
  - Each pulse is high in the first cycle in_val_o shows the new level.
  - Pulses are forced to 0 while state != IDLE, and the masked edge is dropped. in_val_o itself still updates.
- Simultaneous events:
  - Write acceptance and input transition in the same cycle are independent.
  - An ie_o change via the slow path takes effect in APPLY.

Decomposition:
- Package pad_io_ctrl_pkg:
  - state enum pad_io_state_e {IDLE, DRAIN, APPLY, SETTLE}.
  - Constant SettleCycles=2.
  - Attribute bit index constants: Inv=0, OpenDrain=1, PullEn=2, PullSel=3, Keeper=4, Schmitt=5, Slew=6, Drive=8:7.
- Sub-module pad_io_filter: gate, 2-flop synchroniser (prim_flop_2sync), debounce counter and edge register. It takes an edge-mask input driven by state != IDLE.
- Assertion: AttrDw >= 9.

Test Plan:
- Reset: assert rst_ni=0 mid-SETTLE -> all outputs 0 immediately, cfg_ready_o=1 and state IDLE after release.
- WARL masking: warl_i=10'h19F, write cfg_attr_i=10'h3FF with oe_o=0 -> attr_o=10'h19F one cycle later, cfg_ready_o stays 1.
- Break-before-make: oe_o=1 and attr_o=10'h004, write attr 10'h008 oe=1 out=1 -> oe_o low for exactly 4 cycles; attr_o=10'h008 from the APPLY cycle; oe_o=1 afterwards; a cfg_valid_i during the sequence is ignored.
- Unfiltered latency: filt_en_i=0, ie_o=1, in_i 0->1 -> in_val_o=1 exactly 3 cycles later, rise_o high for 1 cycle.
- Debounce: filt_en_i=1, T=5.
  - 5-cycle pulse on in_i -> in_val_o unchanged, no edges.
  - 20-cycle pulse -> in_val_o rises 8 cycles after the in_i rise, followed by fall_o.
- ie gating and masking:
  - ie_o=0 with in_i=x/1 -> in_val_o stays 0.
  - An edge arriving during DRAIN/SETTLE -> in_val_o updates, rise_o stays 0.
